top_fifo: RTL and testbench

- Synchronous single-clock byte FIFO: buffers 8-bit words written on write_en and returns them in order on read_en.
- Sits between a byte producer and a byte consumer in the same clock domain.
- Reports full/empty/occupancy and flags illegal accesses: write when full, read when empty.

---
 rtl/top_fifo.sv | 93 +++++++++
 tb/tb_top_fifo.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/top_fifo.sv
// ============================================================================
// Module   : top_fifo
// Purpose  : Single-clock byte FIFO with registered read data, occupancy and
//            overflow/underflow flags. Define TOP_FIFO_STICKY_ERR_EN to make
//            the error flags sticky until reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module top_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic              read_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic do_write;
  logic do_read;
  logic ovf_evt;
  logic unf_evt;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A write into a full FIFO is legal only when a read frees a slot this cycle.
  assign do_write = write_en && (!full || read_en);
  assign do_read  = read_en && !empty;
  assign ovf_evt  = write_en && full && !read_en;
  assign unf_evt  = read_en && empty;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_read) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
`ifdef TOP_FIFO_STICKY_ERR_EN
      overflow  <= overflow  | ovf_evt;
      underflow <= underflow | unf_evt;
`else
      overflow  <= ovf_evt;
      underflow <= unf_evt;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_top_fifo.sv
// Testbench for top_fifo: directed test-plan steps followed by random traffic,
// all checked against a queue-based reference model.
`default_nettype none

module tb_top_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk;
  logic              reset;
  logic              write_en;
  logic              read_en;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  top_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .write_en(write_en), .read_en(read_en),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_dout = '0;
  logic              exp_ovf  = 1'b0;
  logic              exp_unf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"},     32'(count),     32'(model_q.size()));
    chk({tag, ".empty"},     32'(empty),     32'(model_q.size() == 0));
    chk({tag, ".full"},      32'(full),      32'(model_q.size() == DEPTH));
    chk({tag, ".data_out"},  32'(data_out),  32'(exp_dout));
    chk({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(exp_unf));
  endtask

  // Drive one cycle of requests, advance the model, then check just after the edge.
  task automatic step(input logic we, input logic re, input logic [DATA_W-1:0] d,
                      input string tag);
    bit was_full, was_empty, ovf_evt, unf_evt;
    write_en = we;
    read_en  = re;
    data_in  = d;
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    ovf_evt = we && was_full && !re;
    unf_evt = re && was_empty;
    if (re && !was_empty) exp_dout = model_q.pop_front();
    if (we && (!was_full || re)) model_q.push_back(d);
`ifdef TOP_FIFO_STICKY_ERR_EN
    exp_ovf = exp_ovf | ovf_evt;
    exp_unf = exp_unf | unf_evt;
`else
    exp_ovf = ovf_evt;
    exp_unf = unf_evt;
`endif
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    write_en = 1'b0;
    read_en  = 1'b0;
    data_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk_all("reset");

    // Write then read a single word
    step(1'b1, 1'b0, 8'h0A, "wr1");
    step(1'b0, 1'b1, 8'h00, "rd1");

    // Back-to-back writes and reads
    step(1'b1, 1'b0, 8'h0A, "b2b_w0");
    step(1'b1, 1'b0, 8'h1B, "b2b_w1");
    step(1'b0, 1'b1, 8'h00, "b2b_r0");
    step(1'b0, 1'b1, 8'h00, "b2b_r1");

    // Underflow on an empty FIFO
    step(1'b0, 1'b1, 8'h00, "unf");
    step(1'b0, 1'b0, 8'h00, "unf_after");

    // Overflow: the fifth write is dropped
    step(1'b1, 1'b0, 8'h0A, "ovf_w0");
    step(1'b1, 1'b0, 8'h1B, "ovf_w1");
    step(1'b1, 1'b0, 8'h2C, "ovf_w2");
    step(1'b1, 1'b0, 8'h3D, "ovf_w3");
    step(1'b1, 1'b0, 8'h4E, "ovf_w4");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, "ovf_rd");
    step(1'b0, 1'b0, 8'h00, "ovf_idle");

    // Full with simultaneous read and write
    step(1'b1, 1'b0, 8'h11, "fullrw_w0");
    step(1'b1, 1'b0, 8'h22, "fullrw_w1");
    step(1'b1, 1'b0, 8'h33, "fullrw_w2");
    step(1'b1, 1'b0, 8'h44, "fullrw_w3");
    step(1'b1, 1'b1, 8'h55, "fullrw_both");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, "fullrw_rd");

    // Simultaneous read and write on empty: write lands, read underflows
    step(1'b1, 1'b1, 8'h66, "emptyrw");
    step(1'b0, 1'b1, 8'h00, "emptyrw_rd");

    // Asynchronous reset between clock edges with data queued
    step(1'b1, 1'b0, 8'hA1, "mid_w0");
    step(1'b1, 1'b0, 8'hA2, "mid_w1");
    step(1'b1, 1'b0, 8'hA3, "mid_w2");
    step(1'b0, 1'b1, 8'h00, "mid_r0");
    write_en = 1'b0;
    read_en  = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk_all("async_reset");
    #1;
    reset = 1'b0;
    step(1'b1, 1'b0, 8'h77, "post_w");
    step(1'b0, 1'b1, 8'h00, "post_r");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
           8'($urandom), "rand");
    end
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 8'h00, "drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
